jump_ctrl: RTL and testbench

Parametrised game controller for the bottle-flip jumper; next generation of the existing top-level game FSM. Keeps a NUM_SQ-deep queue of platforms from an internal LFSR. Converts button hold time into a jump length and hands the jump to the renderer over a start/done handshake. Judges the landing and keeps a BCD score with a perfect-hit combo multiplier, plus a lives counter with respawn. Sits between the button debouncer and the VGA renderer; the renderer owns all animation.

---
 rtl/jump_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_jump_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jump_ctrl
// Purpose  : Game controller for the bottle-flip jumper. Keeps a queue of
//            platforms generated from an LFSR, turns button hold time into a
//            jump length, hands the jump to the renderer over a start/done
//            handshake, judges the landing and keeps a BCD score with a
//            perfect-hit combo multiplier and a lives counter.
// Ports    : clk        - system clock
//            restart    - asynchronous active-high reset
//            press      - debounced jump button (level)
//            anim_done  - renderer finished the jump animation (pulse)
//            jump_start - pulse, jump handed to the renderer
//            jump_len   - jump length, loaded when the charge ends
//            cur_dist   - spacing between queue entries 0 and 1
//            cur_rad    - radius of queue entry 1 (the target)
//            offset     - signed player offset from the centre of entry 0
//            score      - BCD score
//            lives      - remaining lives
//            combo      - consecutive perfect count
//            perfect    - pulse after a perfect landing
//            shift      - pulse while the queue advances
//            dead       - high in DEAD
//            state      - current state code
// Revision : 1.0 - initial release
// ============================================================================
module jump_ctrl #(
    parameter int          NUM_SQ       = 4,
    parameter int          SCORE_DIGITS = 4,
    parameter int          LIVES        = 3,
    parameter int          CHG_DIV      = 0,
    parameter int          DIST_MIN     = 13,
    parameter int          PERFECT_TOL  = 1,
    parameter int          NORMAL_HIT   = 1,
    parameter int          PERFECT_HIT  = 2,
    parameter int          COMBO_MAX    = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      restart,
    input  logic                      press,
    input  logic                      anim_done,
    output logic                      jump_start,
    output logic [7:0]                jump_len,
    output logic [7:0]                cur_dist,
    output logic [7:0]                cur_rad,
    output logic [8:0]                offset,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [3:0]                lives,
    output logic [2:0]                combo,
    output logic                      perfect,
    output logic                      shift,
    output logic                      dead,
    output logic [2:0]                state
);

    localparam int                     c_IDX_W    = $clog2(NUM_SQ);
    localparam int                     c_DIV_W    = CHG_DIV + 1;
    localparam logic [c_DIV_W-1:0]     c_DIV_LAST = c_DIV_W'((1 << CHG_DIV) - 1);
    localparam int                     c_SW       = 4 * SCORE_DIGITS;
    localparam logic [c_SW-1:0]        c_SCORE_MAX = {SCORE_DIGITS{4'h9}};

    typedef enum logic [2:0] {
        S_FILL   = 3'd0,
        S_READY  = 3'd1,
        S_CHARGE = 3'd2,
        S_JUMP   = 3'd3,
        S_JUDGE  = 3'd4,
        S_SHIFT  = 3'd5,
        S_FALL   = 3'd6,
        S_DEAD   = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [15:0]          r_lfsr;
    logic [15:0]          w_lfsr_next;
    logic [c_IDX_W-1:0]   r_fill_idx;
    logic [7:0]           r_dist [NUM_SQ];
    logic [7:0]           r_rad  [NUM_SQ];
    logic [7:0]           w_gen_dist;
    logic [7:0]           w_gen_rad;
    logic [4:0]           w_sel;

    logic [7:0]           r_charge;
    logic [c_DIV_W-1:0]   r_div;
    logic                 w_div_tick;
    logic [7:0]           r_jump_len;
    logic                 r_jump_start;

    logic [8:0]           r_offset;
    logic [9:0]           w_p;
    logic [9:0]           w_e;
    logic                 w_hit;
    logic                 w_perf;

    logic [c_SW-1:0]      r_score;
    logic [c_SW-1:0]      w_score_sum;
    logic [3:0]           w_carry;
    logic [4:0]           w_dsum;
    logic [3:0]           w_add;
    logic [2:0]           w_combo_inc;
    logic [2:0]           r_combo;
    logic [3:0]           r_lives;
    logic                 r_perfect;
    logic                 w_shift;
    logic                 w_dead;

    // ------------------------------------------------------------------
    // Galois LFSR x^16+x^14+x^13+x^11, free running in every state
    // ------------------------------------------------------------------
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    // New platform derived from the current LFSR value
    assign w_gen_dist = 8'(DIST_MIN) + {5'd0, r_lfsr[2:0]};
    assign w_sel      = r_lfsr[7:3];

    always_comb begin
        w_gen_rad = 8'd9;
        if (w_sel < 5'd4)       w_gen_rad = 8'd5;
        else if (w_sel < 5'd10) w_gen_rad = 8'd6;
        else if (w_sel < 5'd23) w_gen_rad = 8'd7;
        else if (w_sel < 5'd29) w_gen_rad = 8'd8;
    end

    // ------------------------------------------------------------------
    // Landing judgement: p = offset + jump_len - cur_dist, 10-bit signed
    // ------------------------------------------------------------------
    assign w_p    = {r_offset[8], r_offset} + {2'b00, r_jump_len} - {2'b00, r_dist[1]};
    assign w_e    = w_p[9] ? (10'd0 - w_p) : w_p;
    assign w_hit  = (w_e <= {2'b00, r_rad[1]});
    assign w_perf = w_hit && (w_e <= 10'(PERFECT_TOL));

    assign w_combo_inc = (r_combo >= 3'(COMBO_MAX)) ? 3'(COMBO_MAX) : r_combo + 3'd1;
    // The multiplier uses the combo value after this landing counts
    assign w_add = w_perf ? 4'(4'(PERFECT_HIT) * {1'b0, w_combo_inc}) : 4'(NORMAL_HIT);

    // BCD ripple-carry add; the first digit absorbs the whole increment
    always_comb begin
        w_carry     = w_add;
        w_score_sum = '0;
        w_dsum      = '0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            w_dsum = {1'b0, r_score[4*i +: 4]} + {1'b0, w_carry};
            if (w_dsum > 5'd9) begin
                w_score_sum[4*i +: 4] = 4'(w_dsum - 5'd10);
                w_carry               = 4'd1;
            end else begin
                w_score_sum[4*i +: 4] = w_dsum[3:0];
                w_carry               = 4'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge restart) begin
        if (restart) r_state <= S_FILL;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_shift = 1'b0;
        w_dead  = 1'b0;
        case (r_state)
            S_FILL:   if (r_fill_idx == c_IDX_W'(NUM_SQ - 1)) w_next = S_READY;
            S_READY:  if (press) w_next = S_CHARGE;
            S_CHARGE: if (!press) w_next = S_JUMP;
            S_JUMP:   if (anim_done) w_next = S_JUDGE;
            S_JUDGE:  w_next = w_hit ? S_SHIFT : S_FALL;
            S_SHIFT: begin
                w_next  = S_READY;
                w_shift = 1'b1;
            end
            // lives were already decremented on the edge into FALL
            S_FALL:   w_next = (r_lives != 4'd0) ? S_READY : S_DEAD;
            S_DEAD:   w_dead = 1'b1;
            default:  w_next = S_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // LFSR and platform queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            r_lfsr     <= LFSR_SEED;
            r_fill_idx <= '0;
            for (int i = 0; i < NUM_SQ; i++) begin
                r_dist[i] <= '0;
                r_rad[i]  <= '0;
            end
        end else begin
            r_lfsr <= w_lfsr_next;
            if (r_state == S_FILL) begin
                r_dist[r_fill_idx] <= w_gen_dist;
                r_rad[r_fill_idx]  <= w_gen_rad;
                r_fill_idx         <= r_fill_idx + c_IDX_W'(1);
            end else if (r_state == S_SHIFT) begin
                for (int i = 0; i < NUM_SQ - 1; i++) begin
                    r_dist[i] <= r_dist[i+1];
                    r_rad[i]  <= r_rad[i+1];
                end
                r_dist[NUM_SQ-1] <= w_gen_dist;
                r_rad[NUM_SQ-1]  <= w_gen_rad;
            end
        end
    end

    // ------------------------------------------------------------------
    // Charge accumulation and jump hand-off
    // ------------------------------------------------------------------
    assign w_div_tick = (r_div == c_DIV_LAST);

    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            r_charge     <= '0;
            r_div        <= '0;
            r_jump_len   <= '0;
            r_jump_start <= 1'b0;
        end else begin
            r_jump_start <= (r_state == S_CHARGE) && !press;
            if (r_state == S_READY && press) begin
                r_charge <= '0;
                r_div    <= '0;
            end else if (r_state == S_CHARGE) begin
                if (press) begin
                    if (w_div_tick) begin
                        r_div <= '0;
                        if (r_charge != 8'hFF) r_charge <= r_charge + 8'd1;
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end else begin
                    r_jump_len <= r_charge;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Score, combo, lives and offset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            r_score   <= '0;
            r_combo   <= '0;
            r_lives   <= 4'(LIVES);
            r_perfect <= 1'b0;
            r_offset  <= '0;
        end else begin
            r_perfect <= 1'b0;
            case (r_state)
                S_JUDGE: begin
                    if (w_perf) begin
                        r_perfect <= 1'b1;
                        r_combo   <= w_combo_inc;
                    end else begin
                        r_combo   <= '0;
                    end
                    if (w_hit) begin
                        r_score <= (w_carry != 4'd0) ? c_SCORE_MAX : w_score_sum;
                    end else begin
                        r_lives <= r_lives - 4'd1;
                    end
                end
                S_SHIFT: r_offset <= w_p[8:0];
                S_FALL:  if (r_lives != 4'd0) r_offset <= '0;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs; the queue is not meaningful until it has been filled
    // ------------------------------------------------------------------
    assign cur_dist   = (r_state == S_FILL) ? 8'd0 : r_dist[1];
    assign cur_rad    = (r_state == S_FILL) ? 8'd0 : r_rad[1];
    assign jump_start = r_jump_start;
    assign jump_len   = r_jump_len;
    assign offset     = r_offset;
    assign score      = r_score;
    assign lives      = r_lives;
    assign combo      = r_combo;
    assign perfect    = r_perfect;
    assign shift      = w_shift;
    assign dead       = w_dead;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jump_ctrl
// Purpose  : Self-checking bench for jump_ctrl. A game-level model (software
//            LFSR, platform queue array, integer score) predicts every
//            observable output across randomised jump lengths and animation
//            delays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jump_ctrl;

    localparam int NUM_SQ    = 4;
    localparam int LIVES     = 3;
    localparam int SCORE_MAX = 9999;

    logic        clk = 1'b0;
    logic        restart;
    logic        press;
    logic        anim_done;
    logic        jump_start;
    logic [7:0]  jump_len;
    logic [7:0]  cur_dist;
    logic [7:0]  cur_rad;
    logic [8:0]  offset;
    logic [15:0] score;
    logic [3:0]  lives;
    logic [2:0]  combo;
    logic        perfect;
    logic        shift;
    logic        dead;
    logic [2:0]  state;

    jump_ctrl dut (
        .clk        (clk),
        .restart    (restart),
        .press      (press),
        .anim_done  (anim_done),
        .jump_start (jump_start),
        .jump_len   (jump_len),
        .cur_dist   (cur_dist),
        .cur_rad    (cur_rad),
        .offset     (offset),
        .score      (score),
        .lives      (lives),
        .combo      (combo),
        .perfect    (perfect),
        .shift      (shift),
        .dead       (dead),
        .state      (state)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] m_lfsr;
    int          q_dist [NUM_SQ];
    int          q_rad  [NUM_SQ];
    int          m_off;
    int          m_score;
    int          m_combo;
    int          m_lives;

    function automatic logic [15:0] lfsr_nxt(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR: seeded by restart, one step per clock
    always @(posedge clk or posedge restart) begin
        if (restart) m_lfsr <= 16'hACE1;
        else         m_lfsr <= lfsr_nxt(m_lfsr);
    end

    function automatic int gen_dist(input logic [15:0] l);
        return 13 + int'(l & 16'h7);
    endfunction

    function automatic int gen_rad(input logic [15:0] l);
        int s;
        s = int'((l >> 3) & 16'h1F);
        if (s < 4)  return 5;
        if (s < 10) return 6;
        if (s < 23) return 7;
        if (s < 29) return 8;
        return 9;
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous restart, reset-value checks with no clock edge, then fill
    task automatic do_restart;
        #2 restart = 1'b1;
        press     = 1'b0;
        anim_done = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_score", 32'(score), 0);
        check("rst_lives", 32'(lives), LIVES);
        check("rst_combo", 32'(combo), 0);
        check("rst_offset", 32'(offset), 0);
        check("rst_jump_len", 32'(jump_len), 0);
        check("rst_dist", 32'(cur_dist), 0);
        check("rst_rad", 32'(cur_rad), 0);
        check("rst_pulses", {28'd0, jump_start, perfect, shift, dead}, 0);
        @(posedge clk);
        #1 restart = 1'b0;
        m_off   = 0;
        m_score = 0;
        m_combo = 0;
        m_lives = LIVES;
        for (int i = 0; i < NUM_SQ; i++) begin
            check("fill_state", 32'(state), 0);
            check("fill_dist", 32'(cur_dist), 0);
            q_dist[i] = gen_dist(m_lfsr);
            q_rad[i]  = gen_rad(m_lfsr);
            // press and anim_done are meaningless while filling
            press     = (i < NUM_SQ - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            anim_done = (i < NUM_SQ - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        check("ready_state", 32'(state), 1);
        check("ready_dist", 32'(cur_dist), 32'(q_dist[1]));
        check("ready_rad", 32'(cur_rad), 32'(q_rad[1]));
        check("ready_lives", 32'(lives), LIVES);
    endtask

    // One full jump: hold press for jl+1 cycles, anim_done dly cycles after
    // jump_start, then follow judge and shift/fall against the model
    task automatic jump(input int jl, input int dly);
        int  p;
        int  e;
        int  ejl;
        bit  hit;
        bit  pf;
        check("j_ready", 32'(state), 1);
        press = 1'b1;
        repeat (jl + 1) tick();
        check("j_charge", 32'(state), 2);
        press = 1'b0;
        tick();
        ejl = (jl > 255) ? 255 : jl;
        check("j_state", 32'(state), 3);
        check("j_start", 32'(jump_start), 1);
        check("j_len", 32'(jump_len), 32'(ejl));
        for (int d = 0; d < dly; d++) begin
            press = 1'($urandom_range(0, 1));
            tick();
            check("j_wait", 32'(state), 3);
            check("j_start_off", 32'(jump_start), 0);
        end
        press     = 1'b0;
        anim_done = 1'b1;
        tick();
        anim_done = 1'b0;
        check("j_judge", 32'(state), 4);

        p   = m_off + ejl - q_dist[1];
        e   = (p < 0) ? -p : p;
        hit = (e <= q_rad[1]);
        pf  = hit && (e <= 1);
        if (pf) begin
            m_combo = (m_combo + 1 > 4) ? 4 : m_combo + 1;
            m_score = m_score + 2 * m_combo;
        end else if (hit) begin
            m_combo = 0;
            m_score = m_score + 1;
        end else begin
            m_combo = 0;
            m_lives = m_lives - 1;
        end
        if (m_score > SCORE_MAX) m_score = SCORE_MAX;

        tick();
        check("jd_state", 32'(state), hit ? 5 : 6);
        check("jd_perfect", 32'(perfect), 32'(pf));
        check("jd_combo", 32'(combo), 32'(m_combo));
        check("jd_score", 32'(score), to_bcd(m_score));
        check("jd_lives", 32'(lives), 32'(m_lives));
        check("jd_shift", 32'(shift), 32'(hit));
        if (hit) begin
            for (int i = 0; i < NUM_SQ - 1; i++) begin
                q_dist[i] = q_dist[i+1];
                q_rad[i]  = q_rad[i+1];
            end
            q_dist[NUM_SQ-1] = gen_dist(m_lfsr);
            q_rad[NUM_SQ-1]  = gen_rad(m_lfsr);
            m_off = p;
            tick();
            check("sh_state", 32'(state), 1);
            check("sh_offset", 32'(offset), 32'(m_off & 32'h1FF));
            check("sh_dist", 32'(cur_dist), 32'(q_dist[1]));
            check("sh_rad", 32'(cur_rad), 32'(q_rad[1]));
            check("sh_pulses", {30'd0, perfect, shift}, 0);
        end else begin
            tick();
            if (m_lives > 0) begin
                m_off = 0;
                check("fa_state", 32'(state), 1);
                check("fa_offset", 32'(offset), 0);
                check("fa_dist", 32'(cur_dist), 32'(q_dist[1]));
            end else begin
                check("fa_dead_state", 32'(state), 7);
                check("fa_dead", 32'(dead), 1);
            end
        end
    endtask

    // Aim for landing error err relative to the target centre
    task automatic jump_err(input int err, input int dly);
        jump(q_dist[1] - m_off + err, dly);
    endtask

    initial begin
        int r;
        restart   = 1'b0;
        press     = 1'b0;
        anim_done = 1'b0;
        do_restart();

        // anim_done outside JUMP is ignored
        anim_done = 1'b1;
        tick();
        anim_done = 1'b0;
        check("ad_ignored", 32'(state), 1);

        // Perfect chain: combo 1..4 then capped
        jump_err(0, 5);
        check("first_score", 32'(score), 32'h0002);
        repeat (4) jump_err($urandom_range(0, 2) - 1, $urandom_range(0, 3));
        check("chain_score", 32'(score), 32'h0028);
        check("chain_combo", 32'(combo), 4);

        // Edge-of-platform landing: normal hit, offset carried forward
        jump_err($urandom_range(0, 1) ? q_rad[1] : -q_rad[1], 1);
        check("normal_combo", 32'(combo), 0);

        // Random landings anywhere on the target
        repeat (6) begin
            r = q_rad[1];
            jump_err($urandom_range(0, 2 * r) - r, $urandom_range(0, 4));
        end

        // Saturated charge, then two zero-length jumps: lose all lives
        jump(300, 2);
        jump(0, 0);
        jump(0, 1);
        check("dead_lives", 32'(lives), 0);

        // DEAD holds against press and anim_done
        press = 1'b1;
        repeat (3) tick();
        press     = 1'b0;
        anim_done = 1'b1;
        tick();
        anim_done = 1'b0;
        tick();
        check("hold_state", 32'(state), 7);
        check("hold_dead", 32'(dead), 1);
        check("hold_score", 32'(score), to_bcd(m_score));
        check("hold_lives", 32'(lives), 0);
        check("hold_start", 32'(jump_start), 0);

        // Score saturation through repeated perfect hits
        do_restart();
        while (m_score < SCORE_MAX) jump_err($urandom_range(0, 2) - 1, $urandom_range(0, 2));
        check("sat_score", 32'(score), 32'h9999);
        jump_err(0, 0);
        check("sat_hold", 32'(score), 32'h9999);

        // Restart mid-jump aborts; the late anim_done during fill is ignored
        press = 1'b1;
        repeat (5) tick();
        press = 1'b0;
        tick();
        check("abort_in_jump", 32'(state), 3);
        do_restart();
        jump_err(0, 0);
        check("after_abort_score", 32'(score), 32'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
